// File: rtl/imem_loader_ctrl.sv
// Instruction-memory port owner: assembles UART bytes into words for program load, then hands the port to fetch.
// Optional XOR checksum of written words is built when IMEM_CHECKSUM_EN is defined.
module imem_loader_ctrl #(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load_req,
    input  logic                i_run,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    input  logic [ADDR_W-1:0]   i_fetch_addr,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic                o_mem_we,
    output logic [DATA_W-1:0]   o_fetch_instr,
    output logic                o_fetch_stall,
    output logic                o_loaded,
    output logic [ADDR_W:0]     o_word_count,
    output logic                o_overflow,
    output logic [DATA_W-1:0]   o_checksum
);

    // state | meaning
    // IDLE  | after reset, waiting for a load request
    // LOAD  | collecting bytes into the word register
    // WRITE | one-cycle write of the assembled word
    // READY | program loaded, waiting for run
    // RUN   | fetch owns the memory port
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, READY, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_SLOT = '1;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [1:0]          byte_idx;
    logic [DATA_W-1:0]   word;
    logic                start_load;

    assign start_load = i_load_req && (state == IDLE || state == READY || state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            byte_idx     <= '0;
            word         <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
        end else if (start_load) begin
            state        <= LOAD;
            ptr          <= '0;
            byte_idx     <= '0;
            word         <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (i_rx_valid) begin
                        word <= {word[DATA_W-9:0], i_rx_data};
                        if (byte_idx == 2'd3) begin
                            byte_idx <= '0;
                            state    <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    o_word_count <= o_word_count + 1'b1;
                    // The pointer saturates on the last slot instead of wrapping to 0.
                    if (ptr != LAST_SLOT)
                        ptr <= ptr + 1'b1;
                    if (word == HALT_WORD) begin
                        state <= READY;
                    end else if (ptr == LAST_SLOT) begin
                        state      <= READY;
                        o_overflow <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                READY: begin
                    if (i_run)
                        state <= RUN;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start_load)
            o_checksum <= '0;
        else if (state == WRITE)
            o_checksum <= o_checksum ^ word;
    end
`else
    assign o_checksum = '0;
`endif

    // Port outputs decode straight from the state flop; only the address mux sees i_fetch_addr.
    assign o_mem_we      = (state == WRITE);
    assign o_mem_wdata   = word;
    assign o_mem_addr    = (state == RUN) ? i_fetch_addr : ptr;
    assign o_fetch_instr = (state == RUN) ? i_mem_rdata : '0;
    assign o_fetch_stall = (state != RUN);
    assign o_loaded      = (state == READY) || (state == RUN);

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scoreboard bench for imem_loader_ctrl: expected writes are queued at stimulus time and popped by a write monitor.
module tb_imem_loader_ctrl;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_load_req, i_run, i_rx_valid;
    logic [7:0]        i_rx_data;
    logic [ADDR_W-1:0] i_fetch_addr;
    logic [31:0]       i_mem_rdata;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata, o_fetch_instr, o_checksum;
    logic              o_mem_we, o_fetch_stall, o_loaded, o_overflow;
    logic [ADDR_W:0]   o_word_count;

    imem_loader_ctrl dut (
        .clk(clk), .reset(reset), .i_load_req(i_load_req), .i_run(i_run),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_fetch_addr(i_fetch_addr),
        .i_mem_rdata(i_mem_rdata), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_we(o_mem_we), .o_fetch_instr(o_fetch_instr), .o_fetch_stall(o_fetch_stall),
        .o_loaded(o_loaded), .o_word_count(o_word_count), .o_overflow(o_overflow),
        .o_checksum(o_checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
    wr_t          exp_q[$];
    logic [31:0]  prog[$];
    logic [31:0]  mem[DEPTH];
    logic [31:0]  ref_mem[DEPTH];
    int           total = 0;
    int           bad = 0;
    int           exp_cnt;
    logic         exp_ovf;
    logic [31:0]  exp_ck;

    // Memory model with asynchronous read, written by the DUT.
    assign i_mem_rdata = mem[o_mem_addr];
    always @(posedge clk) if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && o_mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we_addr", {58'd0, o_mem_addr}, 64'hDEAD);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {58'd0, o_mem_addr}, {58'd0, e.addr});
                chk("wr_data", {32'd0, o_mem_wdata}, {32'd0, e.data});
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_load_req();
        @(posedge clk); #1 i_load_req = 1'b1;
        @(posedge clk); #1 i_load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit junk_after);
        @(posedge clk); #1 i_rx_valid = 1'b1; i_rx_data = b;
        @(posedge clk); #1;
        if (junk_after) begin
            i_rx_data = 8'hA5;
            @(posedge clk); #1;
        end
        i_rx_valid = 1'b0;
        tick($urandom_range(0, 2));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0BAD_F00D;
        return w;
    endfunction

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_we"}, {63'd0, o_mem_we}, 64'd0);
        chk({tag, "_addr"}, {58'd0, o_mem_addr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, o_mem_wdata}, 64'd0);
        chk({tag, "_count"}, {57'd0, o_word_count}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, o_overflow}, 64'd0);
        chk({tag, "_loaded"}, {63'd0, o_loaded}, 64'd0);
        chk({tag, "_stall"}, {63'd0, o_fetch_stall}, 64'd1);
        chk({tag, "_ck"}, {32'd0, o_checksum}, 64'd0);
    endtask

    // Reference: words land at consecutive addresses until HALT is stored or memory is full.
    task automatic load_prog(input bit junk);
        bit done;
        exp_cnt = 0; exp_ovf = 1'b0; exp_ck = 32'h0; done = 1'b0;
        foreach (prog[i]) begin
            if (!done) begin
                exp_q.push_back('{addr: ADDR_W'(exp_cnt), data: prog[i]});
                ref_mem[exp_cnt] = prog[i];
`ifdef IMEM_CHECKSUM_EN
                exp_ck ^= prog[i];
`endif
                exp_cnt++;
                if (prog[i] == HALT) done = 1'b1;
                else if (exp_cnt == DEPTH) begin exp_ovf = 1'b1; done = 1'b1; end
            end
        end
        pulse_load_req();
        foreach (prog[i])
            for (int b = 3; b >= 0; b--)
                send_byte(prog[i][8*b +: 8], junk && i == 0 && b == 0);
        for (int i = 0; i < 12 && !o_loaded; i++) @(negedge clk);
        @(negedge clk);
        chk("load_done", {63'd0, o_loaded}, 64'd1);
        chk("word_count", {57'd0, o_word_count}, 64'(exp_cnt));
        chk("overflow", {63'd0, o_overflow}, {63'd0, exp_ovf});
        chk("checksum", {32'd0, o_checksum}, {32'd0, exp_ck});
        chk("ready_stall", {63'd0, o_fetch_stall}, 64'd1);
        chk("ready_instr", {32'd0, o_fetch_instr}, 64'd0);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_and_fetch(input int n_rand);
        @(posedge clk); #1 i_run = 1'b1;
        @(posedge clk); #1 i_run = 1'b0;
        @(negedge clk);
        chk("run_stall", {63'd0, o_fetch_stall}, 64'd0);
        chk("run_loaded", {63'd0, o_loaded}, 64'd1);
        for (int k = 0; k < n_rand + 2; k++) begin
            logic [ADDR_W-1:0] a;
            a = (k < 2) ? ADDR_W'(k) : ADDR_W'($urandom_range(0, DEPTH - 1));
            @(posedge clk); #1 i_fetch_addr = a;
            @(negedge clk);
            chk("fetch_addr", {58'd0, o_mem_addr}, {58'd0, a});
            chk("fetch_instr", {32'd0, o_fetch_instr}, {32'd0, ref_mem[a]});
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        reset = 1'b1; i_load_req = 1'b0; i_run = 1'b0; i_rx_valid = 1'b0;
        i_rx_data = 8'h0; i_fetch_addr = '0;
        tick(3);
        reset = 1'b0;
        check_reset_vals("reset");

        // Basic two-word program, with a byte sent during the WRITE cycle that must be dropped.
        prog = '{32'h2008_0005, HALT};
        load_prog(1'b1);
        run_and_fetch(3);

        // Same-cycle load_req and run while READY: the load wins.
        prog = '{32'h1234_5678, HALT};
        load_prog(1'b0);
        @(posedge clk); #1 i_load_req = 1'b1; i_run = 1'b1;
        @(posedge clk); #1 i_load_req = 1'b0; i_run = 1'b0;
        @(negedge clk);
        chk("tie_loaded", {63'd0, o_loaded}, 64'd0);
        chk("tie_count", {57'd0, o_word_count}, 64'd0);
        chk("tie_stall", {63'd0, o_fetch_stall}, 64'd1);
        chk("tie_ck", {32'd0, o_checksum}, 64'd0);

        // Reset mid-word aborts with no write.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset = 1'b1; tick(1); reset = 1'b0;
        check_reset_vals("abort");
        tick(4);

        // Checksum example: 12345678 ^ FFFFFFFF.
        prog = '{32'h1234_5678, HALT};
        load_prog(1'b0);
`ifdef IMEM_CHECKSUM_EN
        chk("ck_const", {32'd0, o_checksum}, 64'hEDCB_A987);
`else
        chk("ck_const", {32'd0, o_checksum}, 64'd0);
`endif

        // Randomized programs, each reloaded from RUN.
        for (int t = 0; t < 5; t++) begin
            int n;
            n = $urandom_range(1, 10);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(rand_word());
            prog.push_back(HALT);
            load_prog(t[0]);
            run_and_fetch(4);
        end

        // Fill all 64 slots without HALT: overflow and no 65th write.
        prog.delete();
        for (int i = 0; i < DEPTH; i++) prog.push_back(rand_word());
        load_prog(1'b0);
        for (int b = 0; b < 4; b++) send_byte(8'h5A, 1'b0);
        tick(3);
        chk("ovf_count_hold", {57'd0, o_word_count}, 64'd64);
        chk("ovf_hold", {63'd0, o_overflow}, 64'd1);
        run_and_fetch(8);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
